// File: rtl/countdown_timer.sv
// Loadable down-counting timer with start/pause/abort control; terminal count flagged on borrow_out.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic auto-reload instead of one-shot DONE.
module countdown_timer #(
  parameter int unsigned NUMBER_OF_BIT = 4,
  parameter int unsigned RST_VALUE     = 12
) (
  input  logic                     clk,
  input  logic                     glob_rst_n,
  input  logic                     ce,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     load,
  input  logic [NUMBER_OF_BIT-1:0] load_value,
  output logic [NUMBER_OF_BIT-1:0] cnt,
  output logic                     borrow_out,
  output logic                     busy,
  output logic                     done
);

  localparam logic [NUMBER_OF_BIT-1:0] RST_CNT = NUMBER_OF_BIT'(RST_VALUE);
  localparam logic [NUMBER_OF_BIT-1:0] ONE     = NUMBER_OF_BIT'(1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t                   state, state_next;
  logic [NUMBER_OF_BIT-1:0] reload, reload_next, cnt_next;
  logic                     borrow_next, busy_next, done_next;

  always_ff @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      state      <= IDLE;
      cnt        <= RST_CNT;
      reload     <= RST_CNT;
      borrow_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      reload     <= reload_next;
      borrow_out <= borrow_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    reload_next = reload;
    borrow_next = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          reload_next = load_value;
          cnt_next    = load_value;
        end
        if (start && !stop) state_next = RUN;
      end
      RUN: begin
        // stop has priority; a ce in the same cycle is dropped
        if (stop) begin
          state_next = PAUSE;
        end else if (ce) begin
          if (cnt != '0) begin
            cnt_next = cnt - ONE;
          end else begin
            borrow_next = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            cnt_next    = reload;
`else
            state_next  = DONE;
`endif
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_next = IDLE;
          cnt_next   = reload;
        end else if (start) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (load) begin
          reload_next = load_value;
          cnt_next    = load_value;
          state_next  = (start && !stop) ? RUN : IDLE;
        end else if (start && !stop) begin
          cnt_next   = reload;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status is decoded from the next state so busy/done come straight from flops.
  always_comb begin
    busy_next = (state_next == RUN) || (state_next == PAUSE);
    done_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (one-shot build, or auto-reload
// when COUNTDOWN_AUTO_RELOAD_EN is defined).
`timescale 1ns/1ps
module tb_countdown_timer;

  logic       clk, glob_rst_n, ce, start, stop, load;
  logic [3:0] load_value, cnt;
  logic       borrow_out, busy, done;
  int         compared = 0;
  int         mismatched = 0;

  countdown_timer #(.NUMBER_OF_BIT(4), .RST_VALUE(12)) dut (
    .clk(clk), .glob_rst_n(glob_rst_n), .ce(ce), .start(start), .stop(stop),
    .load(load), .load_value(load_value), .cnt(cnt), .borrow_out(borrow_out),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int c, input int b, input int bz, input int d);
    check({tag, ".cnt"}, 32'(cnt), c);
    check({tag, ".borrow"}, 32'(borrow_out), b);
    check({tag, ".busy"}, 32'(busy), bz);
    check({tag, ".done"}, 32'(done), d);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    glob_rst_n = 1'b1; ce = 0; start = 0; stop = 0; load = 0; load_value = '0;
    #1 glob_rst_n = 1'b0;
    #1 check_all("reset", 12, 0, 0, 0);
    @(negedge clk) glob_rst_n = 1'b1;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    start = 1; ce = 1; tick(); start = 0;
    check_all("ar_start", 12, 0, 1, 0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      check("ar_cnt", 32'(cnt), (k % 13 == 0) ? 12 : 12 - (k % 13));
      check("ar_borrow", 32'(borrow_out), (k % 13 == 0) ? 1 : 0);
      check("ar_done", 32'(done), 0);
    end
`else
    // full count from reset value with ce every cycle
    start = 1; ce = 1; tick(); start = 0;
    check_all("run_entry", 12, 0, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("count_down", 32'(cnt), 12 - i);
      check("no_early_borrow", 32'(borrow_out), 0);
    end
    tick();
    check_all("terminal", 0, 1, 0, 1);
    tick(); tick();
    check_all("done_hold", 0, 0, 0, 1);
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    check_all("done_stop_wins", 0, 0, 0, 1);

    // load from DONE to IDLE, then load+start in IDLE, ce every other cycle
    ce = 0; load = 1; load_value = 5; tick(); load = 0;
    check_all("done_load", 5, 0, 0, 0);
    load = 1; load_value = 3; start = 1; tick(); load = 0; start = 0;
    check_all("idle_load_start", 3, 0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      ce = 1; tick(); ce = 0;
      check("slow_ce", 32'(cnt), 3 - k);
      load = 1; load_value = 9; tick(); load = 0;
      check("run_load_ignored", 32'(cnt), 3 - k);
    end
    ce = 1; tick(); ce = 0;
    check_all("terminal_3", 0, 1, 0, 1);
    tick();
    check("borrow_one_cycle", 32'(borrow_out), 0);

    // loaded zero terminates on the first ce
    load = 1; load_value = 0; start = 1; tick(); load = 0; start = 0;
    check_all("zero_run", 0, 0, 1, 0);
    ce = 1; tick(); ce = 0;
    check_all("zero_terminal", 0, 1, 0, 1);

    // pause at 7 with ce active, resume
    load = 1; load_value = 12; tick(); load = 0;
    check_all("reload12", 12, 0, 0, 0);
    start = 1; tick(); start = 0;
    ce = 1;
    for (int k = 0; k < 5; k++) tick();
    check("run_to_7", 32'(cnt), 7);
    stop = 1; tick(); stop = 0;
    check_all("pause_entry", 7, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_all("pause_hold", 7, 0, 1, 0);
    end
    ce = 0; start = 1; tick(); start = 0;
    check_all("resume", 7, 0, 1, 0);
    ce = 1; tick();
    check("resume_dec6", 32'(cnt), 6);
    tick(); ce = 0;
    check("resume_dec5", 32'(cnt), 5);

    // abort from PAUSE restores the reload value
    stop = 1; tick();
    check_all("pause_at5", 5, 0, 1, 0);
    tick(); stop = 0;
    check_all("abort", 12, 0, 0, 0);
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    check_all("idle_stop_wins", 12, 0, 0, 0);
    ce = 1; tick(); ce = 0;
    check("idle_no_count", 32'(cnt), 12);

    // asynchronous reset mid-run restores reset value in reload register
    load = 1; load_value = 3; start = 1; tick(); load = 0; start = 0;
    ce = 1; tick(); ce = 0;
    check_all("pre_reset_run", 2, 0, 1, 0);
    #2 glob_rst_n = 1'b0;
    #1 check_all("async_reset", 12, 0, 0, 0);
    @(negedge clk) glob_rst_n = 1'b1;
    start = 1; tick(); start = 0;
    stop = 1; tick(); tick(); stop = 0;
    check_all("reload_after_reset", 12, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
